cache_wb_ctrl: RTL and testbench
================================

Name: cache_wb_ctrl

Overview:
Parametrised direct-mapped, write-back, write-allocate data cache for the multi-cycle MIPS core. It generalises line count and line width, and owns the whole miss sequence: victim write-back, refill and response, driven by its own FSM over a req/ack memory handshake. It adds a full-cache flush and a saturating miss counter. It sits between the core's load/store stage and main memory.

Parameters:
ADDR_W, 32, byte-address width.
NUM_LINES, 4, number of lines; power of 2, at least 2. IDX_W = log2(NUM_LINES).
LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2. OFF_W = log2(LINE_WORDS).
CNT_W, 16, width of the miss counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  access request; held with addr/we/wdata until cpu_ready
cpu_we  in  1  1 = store word, 0 = load word
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
cpu_wdata  in  32  store data
cpu_ready  out  1  one-cycle pulse: access complete
cpu_rdata  out  32  load data, valid while cpu_ready=1
flush  in  1  single-cycle pulse: write back all dirty lines
flush_done  out  1  one-cycle pulse when the flush completes
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  1 = line write-back, 0 = line refill
mem_addr  out  ADDR_W-2-OFF_W  line address {tag,index}
mem_wdata  out  32*LINE_WORDS  victim line, word 0 in the MSBs
mem_rdata  in  32*LINE_WORDS  refill line, word 0 in the MSBs
mem_ack  in  1  one-cycle pulse completing a mem_req
miss_count  out  CNT_W  saturating count of misses
dbg_index  in  IDX_W  debug line select
dbg_word  in  OFF_W  debug word select
dbg_data  out  32  combinational array[dbg_index][dbg_word]
dbg_valid  out  1  combinational valid bit of dbg_index
dbg_dirty  out  1  combinational dirty bit of dbg_index

Behaviour:
- Address split: word offset = addr[OFF_W+1:2]; index = addr[OFF_W+IDX_W+1:OFF_W+2]; tag = remaining upper bits.
- Reset: state IDLE. All valid, dirty, tag and data bits are 0. Outputs cpu_ready, flush_done, mem_req and mem_we are 0. cpu_rdata, mem_addr, mem_wdata and miss_count are 0. Reset mid-transaction aborts it; mem_req is 0 after the edge.
- FSM states: IDLE, WRITEBACK, REFILL, RESPOND, FLUSH.
- IDLE: flush has priority over cpu_req in the same cycle. If cpu_req is also pending, it is serviced after flush_done.
- Hit (IDLE, cpu_req, valid and tag match) at edge N:
  - Load: cpu_rdata is registered.
  - Store: the word is written and dirty is set.
  - cpu_ready=1 in cycle N+1, giving 1-cycle latency. FSM stays in IDLE.
  - The core drops cpu_req in N+1; cpu_req seen high in the cycle after cpu_ready is a new request.
- Miss: miss_count increments, saturating at all-ones.
  - Victim valid and dirty: go to WRITEBACK with mem_we=1, mem_addr={victim tag,index}, mem_wdata=line.
  - Otherwise: go to REFILL with mem_we=0, mem_addr={req tag,index}.
- WRITEBACK: hold mem_req and all mem_* outputs stable until mem_ack. On ack, clear dirty and go to REFILL; mem_req stays 1 with mem_we=0.
- REFILL: on mem_ack, install mem_rdata, set the tag, valid=1, dirty=0. Then merge the access in the same edge:
  - Store overwrites its word and sets dirty.
  - Load captures its word into cpu_rdata.
  - Go to RESPOND.
- RESPOND: cpu_ready=1 for one cycle, then return to IDLE. Miss latency is (memory cycles + 1).
- FLUSH: an IDX_W-bit counter scans indices 0 to NUM_LINES-1, one index per cycle when the line is clean or invalid.
  - Dirty lines are written back with the WRITEBACK handshake, then the dirty bit is cleared; valid and data are retained.
  - After the last index, flush_done=1 for one cycle and the FSM returns to IDLE.
  - A flush with no dirty lines takes exactly NUM_LINES cycles before flush_done.
- The flush pulse is ignored outside IDLE.
- mem_ack outside WRITEBACK/REFILL is ignored.

Test Plan:
- Reset, load 0x00000014 (index 1, word 1), mem_rdata words {A,B,C,D}, ack after 3 cycles -> mem_req=1, mem_we=0, mem_addr=0x0000001; cpu_rdata=B; miss_count=1.
- Store 0xDEADBEEF to 0x18 after that refill -> hit, cpu_ready 1 cycle later, dbg_index=1/dbg_word=2 shows DEADBEEF, dbg_dirty=1, no mem_req.
- Load 0x54 (same index 1, new tag) -> WRITEBACK mem_addr=0x0000001 with mem_wdata={A,B,DEADBEEF,D}, then REFILL mem_addr=0x0000005; miss_count=2.
- Store to lines 0 and 3, then pulse flush -> exactly 2 write-backs, in index order; flush_done pulses once; dbg_dirty=0 for all lines and dbg_valid is unchanged.
- Assert reset while mem_req=1 in REFILL -> mem_req=0 next cycle; all dbg_valid=0; next access to the same address misses.
- Force 2^CNT_W+3 misses (CNT_W=4 build) -> miss_count holds at 0xF.

Source files
------------

// File: rtl/cache_wb_ctrl.sv
// cache_wb_ctrl: direct-mapped write-back write-allocate data cache with flush and saturating miss counter
module cache_wb_ctrl #(
  parameter int ADDR_W = 32,
  parameter int NUM_LINES = 4,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(NUM_LINES),
  localparam int OFF_W = $clog2(LINE_WORDS),
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W,
  localparam int LINE_W = 32 * LINE_WORDS
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_cpu_req,
  input  logic                    i_cpu_we,
  input  logic [ADDR_W-1:0]       i_cpu_addr,
  input  logic [31:0]             i_cpu_wdata,
  output logic                    o_cpu_ready,
  output logic [31:0]             o_cpu_rdata,
  input  logic                    i_flush,
  output logic                    o_flush_done,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_W-3-OFF_W:0] o_mem_addr,
  output logic [LINE_W-1:0]       o_mem_wdata,
  input  logic [LINE_W-1:0]       i_mem_rdata,
  input  logic                    i_mem_ack,
  output logic [CNT_W-1:0]        o_miss_count,
  input  logic [IDX_W-1:0]        i_dbg_index,
  input  logic [OFF_W-1:0]        i_dbg_word,
  output logic [31:0]             o_dbg_data,
  output logic                    o_dbg_valid,
  output logic                    o_dbg_dirty
);
  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL, RESPOND, FLUSH} state_t;
  function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line, input logic [OFF_W-1:0] off);
    return line[LINE_W-1-32*int'(off) -: 32];
  endfunction
  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line, input logic [OFF_W-1:0] off, input logic [31:0] w);
    logic [LINE_W-1:0] l;
    l = line;
    l[LINE_W-1-32*int'(off) -: 32] = w;
    return l;
  endfunction
  state_t r_state, w_next;
  logic [LINE_W-1:0] r_data [NUM_LINES];
  logic [TAG_W-1:0] r_tag [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid, r_dirty;
  logic [IDX_W-1:0] r_cnt;
  logic r_flush, r_ready, r_fdone;
  logic [31:0] r_rdata;
  logic [ADDR_W-3-OFF_W:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [CNT_W-1:0] r_miss;
  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic w_hit, w_victim_dirty, w_flush_dirty, w_last, w_unused;
  assign w_off = i_cpu_addr[OFF_W+1:2];
  assign w_idx = i_cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag = i_cpu_addr[ADDR_W-1:OFF_W+IDX_W+2];
  assign w_unused = ^i_cpu_addr[1:0];
  assign w_hit = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];
  assign w_flush_dirty = r_valid[r_cnt] & r_dirty[r_cnt];
  assign w_last = r_cnt == IDX_W'(NUM_LINES - 1);
  assign o_cpu_ready = r_ready;
  assign o_cpu_rdata = r_rdata;
  assign o_flush_done = r_fdone;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_miss_count = r_miss;
  assign o_dbg_data = get_word(r_data[i_dbg_index], i_dbg_word);
  assign o_dbg_valid = r_valid[i_dbg_index];
  assign o_dbg_dirty = r_dirty[i_dbg_index];
  always_ff @(posedge i_clk)
    r_state <= i_reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = i_flush ? FLUSH : (!i_cpu_req || w_hit) ? IDLE : w_victim_dirty ? WRITEBACK : REFILL;
      WRITEBACK: w_next = !i_mem_ack ? WRITEBACK : r_flush ? FLUSH : REFILL;
      REFILL:    w_next = i_mem_ack ? RESPOND : REFILL;
      RESPOND:   w_next = IDLE;
      FLUSH:     w_next = w_flush_dirty ? WRITEBACK : w_last ? IDLE : FLUSH;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    o_mem_req = r_state == WRITEBACK || r_state == REFILL;
    o_mem_we = r_state == WRITEBACK;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_data[i] <= '0;
        r_tag[i] <= '0;
      end
      r_valid <= '0;
      r_dirty <= '0;
      r_cnt <= '0;
      r_flush <= 1'b0;
      r_ready <= 1'b0;
      r_fdone <= 1'b0;
      r_rdata <= '0;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
      r_miss <= '0;
    end else begin
      r_ready <= 1'b0;
      r_fdone <= 1'b0;
      case (r_state)
        IDLE:
          if (i_flush) begin
            r_flush <= 1'b1;
            r_cnt <= '0;
          end else if (i_cpu_req && w_hit) begin
            r_ready <= 1'b1;
            if (i_cpu_we) begin
              r_data[w_idx] <= put_word(r_data[w_idx], w_off, i_cpu_wdata);
              r_dirty[w_idx] <= 1'b1;
            end else
              r_rdata <= get_word(r_data[w_idx], w_off);
          end else if (i_cpu_req) begin
            if (~&r_miss)
              r_miss <= r_miss + CNT_W'(1);
            r_mem_addr <= w_victim_dirty ? {r_tag[w_idx], w_idx} : {w_tag, w_idx};
            r_mem_wdata <= r_data[w_idx];
          end
        WRITEBACK:
          if (i_mem_ack) begin
            r_dirty[r_mem_addr[IDX_W-1:0]] <= 1'b0;
            r_mem_addr <= {w_tag, w_idx};
          end
        REFILL:
          if (i_mem_ack) begin
            r_data[w_idx] <= i_cpu_we ? put_word(i_mem_rdata, w_off, i_cpu_wdata) : i_mem_rdata;
            r_tag[w_idx] <= w_tag;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= i_cpu_we;
            r_ready <= 1'b1;
            if (!i_cpu_we)
              r_rdata <= get_word(i_mem_rdata, w_off);
          end
        FLUSH:
          if (w_flush_dirty) begin
            r_mem_addr <= {r_tag[r_cnt], r_cnt};
            r_mem_wdata <= r_data[r_cnt];
          end else if (w_last) begin
            r_flush <= 1'b0;
            r_fdone <= 1'b1;
          end else
            r_cnt <= r_cnt + IDX_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_wb_ctrl.sv
// tb_cache_wb_ctrl: directed self-checking bench for cache_wb_ctrl
module tb_cache_wb_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, cpu_req, cpu_we, flush, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_data;
  logic [127:0] mem_rdata, mem_wdata;
  logic cpu_ready, flush_done, mem_req, mem_we, dbg_valid, dbg_dirty;
  logic [27:0] mem_addr;
  logic [15:0] miss_count;
  logic [1:0] dbg_index, dbg_word;
  logic s_ready, s_fdone, s_mreq, s_mwe, s_dbgv, s_dbgdirty;
  logic [31:0] s_rdata, s_dbgd;
  logic [27:0] s_maddr;
  logic [127:0] s_mwdata;
  logic [3:0] s_miss;
  int n_vec = 0;
  int n_err = 0;
  localparam logic [127:0] L1 = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  localparam logic [127:0] L2 = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  localparam logic [127:0] L0 = {32'h90000000, 32'h90000001, 32'h90000002, 32'h90000003};
  localparam logic [127:0] L3 = {32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003};
  cache_wb_ctrl u_dut (
    .i_clk(clk), .i_reset(reset), .i_cpu_req(cpu_req), .i_cpu_we(cpu_we),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_ready(cpu_ready),
    .o_cpu_rdata(cpu_rdata), .i_flush(flush), .o_flush_done(flush_done),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .o_miss_count(miss_count), .i_dbg_index(dbg_index), .i_dbg_word(dbg_word),
    .o_dbg_data(dbg_data), .o_dbg_valid(dbg_valid), .o_dbg_dirty(dbg_dirty)
  );
  cache_wb_ctrl #(.CNT_W(4)) u_sat (
    .i_clk(clk), .i_reset(reset), .i_cpu_req(cpu_req), .i_cpu_we(cpu_we),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_ready(s_ready),
    .o_cpu_rdata(s_rdata), .i_flush(flush), .o_flush_done(s_fdone),
    .o_mem_req(s_mreq), .o_mem_we(s_mwe), .o_mem_addr(s_maddr),
    .o_mem_wdata(s_mwdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .o_miss_count(s_miss), .i_dbg_index(dbg_index), .i_dbg_word(dbg_word),
    .o_dbg_data(s_dbgd), .o_dbg_valid(s_dbgv), .o_dbg_dirty(s_dbgdirty)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
  endtask
  task automatic serve(input string tag, input logic exp_we, input logic [27:0] exp_addr,
                       input logic [127:0] exp_wd, input logic [127:0] rd, input int dly);
    int t = 0;
    while (mem_req !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk({tag, " req"}, mem_req, 1'b1);
    chk({tag, " we"}, mem_we, exp_we);
    chk({tag, " addr"}, mem_addr, exp_addr);
    if (exp_we)
      chk({tag, " wdata"}, mem_wdata, exp_wd);
    repeat (dly) tick();
    if (dly > 0)
      chk({tag, " held"}, {mem_req, mem_we, mem_addr}, {1'b1, exp_we, exp_addr});
    mem_rdata = rd;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask
  task automatic wait_ready(input string tag);
    int t = 0;
    while (cpu_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk({tag, " ready"}, cpu_ready, 1'b1);
    cpu_req = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t;
    int extra;
    reset = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    flush = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    dbg_index = '0;
    dbg_word = '0;
    repeat (2) tick();
    chk("rst cpu_ready", cpu_ready, 1'b0);
    chk("rst flush_done", flush_done, 1'b0);
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst cpu_rdata", cpu_rdata, 32'h0);
    chk("rst mem_addr", mem_addr, 28'h0);
    chk("rst mem_wdata", mem_wdata, 128'h0);
    chk("rst miss_count", miss_count, 16'h0);
    for (int i = 0; i < 4; i++) begin
      dbg_index = i[1:0];
      #1;
      chk($sformatf("rst valid%0d", i), dbg_valid, 1'b0);
    end
    reset = 1'b0;
    tick();
    issue(1'b0, 32'h14, 32'h0);
    serve("refill 0x14", 1'b0, 28'h1, 128'h0, L1, 3);
    wait_ready("ld 0x14");
    chk("ld 0x14 rdata", cpu_rdata, 32'h22222222);
    chk("ld 0x14 miss", miss_count, 16'd1);
    tick();
    chk("ld 0x14 ready pulse", cpu_ready, 1'b0);
    chk("ld 0x14 mem idle", mem_req, 1'b0);
    issue(1'b1, 32'h18, 32'hDEADBEEF);
    tick();
    chk("st 0x18 hit latency", cpu_ready, 1'b1);
    chk("st 0x18 no mem", mem_req, 1'b0);
    cpu_req = 1'b0;
    dbg_index = 2'd1;
    dbg_word = 2'd2;
    #1;
    chk("st 0x18 dbg_data", dbg_data, 32'hDEADBEEF);
    chk("st 0x18 dbg_dirty", dbg_dirty, 1'b1);
    tick();
    chk("st 0x18 ready pulse", cpu_ready, 1'b0);
    chk("st 0x18 miss", miss_count, 16'd1);
    issue(1'b0, 32'h54, 32'h0);
    serve("wb line1", 1'b1, 28'h1, {32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h44444444}, 128'h0, 1);
    serve("refill 0x54", 1'b0, 28'h5, 128'h0, L2, 0);
    wait_ready("ld 0x54");
    chk("ld 0x54 rdata", cpu_rdata, 32'h66666666);
    chk("ld 0x54 miss", miss_count, 16'd2);
    dbg_index = 2'd1;
    #1;
    chk("ld 0x54 dirty", dbg_dirty, 1'b0);
    tick();
    issue(1'b1, 32'h00, 32'h0A0A0A0A);
    serve("refill 0x00", 1'b0, 28'h0, 128'h0, L0, 0);
    wait_ready("st 0x00");
    tick();
    issue(1'b1, 32'h30, 32'h3C3C3C3C);
    serve("refill 0x30", 1'b0, 28'h3, 128'h0, L3, 0);
    wait_ready("st 0x30");
    tick();
    chk("stores miss", miss_count, 16'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    serve("flush wb0", 1'b1, 28'h0, {32'h0A0A0A0A, 32'h90000001, 32'h90000002, 32'h90000003}, 128'h0, 0);
    serve("flush wb3", 1'b1, 28'h3, {32'h3C3C3C3C, 32'hC0000001, 32'hC0000002, 32'hC0000003}, 128'h0, 0);
    t = 0;
    extra = 0;
    while (flush_done !== 1'b1 && t < 20) begin
      if (mem_req)
        extra++;
      tick();
      t++;
    end
    chk("flush done", flush_done, 1'b1);
    chk("flush extra wb", extra, 0);
    tick();
    chk("flush done pulse", flush_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dbg_index = i[1:0];
      #1;
      chk($sformatf("flush dirty%0d", i), dbg_dirty, 1'b0);
      chk($sformatf("flush valid%0d", i), dbg_valid, i != 2);
    end
    issue(1'b0, 32'h54, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush prio ready", cpu_ready, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk($sformatf("clean flush early%0d", k), flush_done, 1'b0);
      chk($sformatf("clean flush hold%0d", k), cpu_ready, 1'b0);
    end
    tick();
    chk("clean flush done", flush_done, 1'b1);
    chk("clean flush no mem", mem_req, 1'b0);
    tick();
    chk("post flush ready", cpu_ready, 1'b1);
    chk("post flush rdata", cpu_rdata, 32'h66666666);
    chk("post flush done pulse", flush_done, 1'b0);
    cpu_req = 1'b0;
    tick();
    issue(1'b0, 32'h80, 32'h0);
    tick();
    chk("abort mem_req", mem_req, 1'b1);
    chk("abort mem_addr", mem_addr, 28'h8);
    reset = 1'b1;
    cpu_req = 1'b0;
    tick();
    chk("abort req low", mem_req, 1'b0);
    chk("abort miss", miss_count, 16'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_index = i[1:0];
      #1;
      chk($sformatf("abort valid%0d", i), dbg_valid, 1'b0);
    end
    reset = 1'b0;
    tick();
    issue(1'b0, 32'h80, 32'h0);
    serve("remiss 0x80", 1'b0, 28'h8, 128'h0, L0, 0);
    wait_ready("ld 0x80");
    chk("ld 0x80 rdata", cpu_rdata, 32'h90000000);
    chk("ld 0x80 miss", miss_count, 16'd1);
    tick();
    for (int i = 0; i < 19; i++) begin
      issue(1'b0, 32'((i + 3) << 6), 32'h0);
      serve($sformatf("sat%0d", i), 1'b0, 28'((i + 3) << 2), 128'h0, {4{32'(i)}}, 0);
      wait_ready($sformatf("sat%0d", i));
      tick();
      if (i == 12)
        chk("sat count 14", s_miss, 4'hE);
    end
    chk("sat count hold", s_miss, 4'hF);
    chk("wide count", miss_count, 16'd20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
